run_launcher: RTL

Front-end sequencer that sits directly upstream of the `lab3` CPU core. It queues program start addresses, launches each run on the CPU with a single-cycle start pulse, and waits for the core's `done`. For every run it reports the start address and the dynamic cycle count. This replaces hand-driven start/wait sequencing and allows several programs to be batched back to back.

---
 rtl/run_launcher.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/run_launcher.sv
// run_launcher: queues CPU start addresses, launches each run with a one-cycle start pulse and
// reports start address and cycle count per run. Define RUN_TIMEOUT_EN to abort hung runs.
module run_launcher #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 15,
  parameter int TIMEOUT = 20000
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  input  logic              go_i,
  output logic              start_o,
  output logic [ADDR_W-1:0] start_addr_o,
  input  logic              done_i,
  output logic              res_valid_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic [CNT_W-1:0]  res_cycles_o,
  output logic              res_timeout_o,
  output logic              busy_o,
  output logic              all_done_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_ARM, S_RUN, S_REPORT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              res_valid_q, res_valid_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
  logic              res_to_q, res_to_d;
  logic              busy_q, busy_d;
  logic              all_done_q, all_done_d;
  logic              push, pop, timed_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

`ifdef RUN_TIMEOUT_EN
  assign timed_out = (cnt_q >= CNT_W'(TIMEOUT));
`else
  assign timed_out = 1'b0;
`endif

  assign req_ready_o = (occ_q != OCC_W'(DEPTH));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_d      = 1'b0;
    addr_d       = addr_q;
    res_valid_d  = 1'b0;
    res_addr_d   = res_addr_q;
    res_cycles_d = res_cycles_q;
    res_to_d     = res_to_q;
    all_done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go_i) begin
          if (occ_q != '0) state_d = S_LAUNCH;
          else             all_done_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        cnt_d   = sat_inc(cnt_q);
        state_d = S_ARM;
      end
      // A done level left over from the previous run must drop before RUN may finish.
      S_ARM: begin
        cnt_d = sat_inc(cnt_q);
        if (timed_out)    state_d = S_REPORT;
        else if (!done_i) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = sat_inc(cnt_q);
        if (done_i || timed_out) state_d = S_REPORT;
      end
      S_REPORT: state_d = (occ_q != '0) ? S_LAUNCH : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    push     = req_valid_i && req_ready_o;
    pop      = (state_d == S_LAUNCH);
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);

    if (pop) begin
      start_d = 1'b1;
      addr_d  = mem_q[rd_ptr_q];
      cnt_d   = '0;
    end
    // all_done must coincide with the result, so it looks at occupancy after this edge.
    if (state_d == S_REPORT) begin
      res_valid_d  = 1'b1;
      res_addr_d   = addr_q;
      res_to_d     = timed_out && !(state_q == S_RUN && done_i);
      res_cycles_d = res_to_d ? CNT_W'(TIMEOUT) : cnt_q;
      all_done_d   = (occ_d == '0);
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      addr_q       <= '0;
      res_valid_q  <= 1'b0;
      res_addr_q   <= '0;
      res_cycles_q <= '0;
      res_to_q     <= 1'b0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      addr_q       <= addr_d;
      res_valid_q  <= res_valid_d;
      res_addr_q   <= res_addr_d;
      res_cycles_q <= res_cycles_d;
      res_to_q     <= res_to_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
    end
  end

  // Queue storage holds data only, so it carries no reset.
  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= req_addr_i;
  end

  assign start_o       = start_q;
  assign start_addr_o  = addr_q;
  assign res_valid_o   = res_valid_q;
  assign res_addr_o    = res_addr_q;
  assign res_cycles_o  = res_cycles_q;
  assign res_timeout_o = res_to_q;
  assign busy_o        = busy_q;
  assign all_done_o    = all_done_q;
endmodule
